dlsc_axid_slave_ram: RTL and testbench

DLSC_AXID_SLAVE_RAM -- requirements
Module: dlsc_axid_slave_ram

---
 rtl/dlsc_axid_pkg.sv | 26 ++
 rtl/dlsc_axid_ram_bytewr.sv | 34 +++
 rtl/dlsc_axid_slave_ram.sv | 176 +++++++++++++++++
 tb/tb_dlsc_axid_slave_ram.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlsc_axid_pkg.sv
// Shared definitions for the AXI-lite-style slave RAM: response codes,
// channel FSM encodings and an address-offset helper.
package dlsc_axid_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    // Number of byte-offset address bits below the word index.
    function automatic int axid_lsb(input int width);
        return $clog2(width / 8);
    endfunction

endpackage

// File: rtl/dlsc_axid_ram_bytewr.sv
// 1R1W synchronous RAM with per-byte write enables; a read of the word being
// written in the same cycle returns the old contents.
module dlsc_axid_ram_bytewr #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic [WIDTH/8-1:0]   i_wr_strb,
    input  logic                 i_rd_en,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic [WIDTH-1:0]     o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_BITS)-1];

    // NOTE: the array has no reset so it maps onto block RAM; non-blocking
    // writes make a same-cycle read see the pre-write value (read-first).
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < WIDTH/8; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/dlsc_axid_slave_ram.sv
// Burst-capable slave RAM with independent read and write channel FSMs.
// Define DLSC_AXID_SLAVE_RAM_STALL_EN to insert LFSR-driven back-pressure.
module dlsc_axid_slave_ram
    import dlsc_axid_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_BITS = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic               axid_ar_ready,
    input  logic               axid_ar_valid,
    input  logic [31:0]        axid_ar_addr,
    input  logic [3:0]         axid_ar_len,
    input  logic               axid_r_ready,
    output logic               axid_r_valid,
    output logic               axid_r_last,
    output logic [WIDTH-1:0]   axid_r_data,
    output logic [1:0]         axid_r_resp,
    output logic               axid_aw_ready,
    input  logic               axid_aw_valid,
    input  logic [31:0]        axid_aw_addr,
    input  logic [3:0]         axid_aw_len,
    output logic               axid_w_ready,
    input  logic               axid_w_valid,
    input  logic               axid_w_last,
    input  logic [WIDTH-1:0]   axid_w_data,
    input  logic [WIDTH/8-1:0] axid_w_strb,
    input  logic               axid_b_ready,
    output logic               axid_b_valid,
    output logic [1:0]         axid_b_resp
);

    localparam int LSB = axid_lsb(WIDTH);

    logic w_stall;

`ifdef DLSC_AXID_SLAVE_RAM_STALL_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= 16'hACE1;
        else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // ---------------- read channel ----------------
    r_state_t              r_rd_state, w_rd_next;
    logic [DEPTH_BITS-1:0] r_rd_index;
    logic [4:0]            r_rd_remain;
    logic                  r_rd_oor;
    logic                  w_ar_hs, w_r_hs, w_rd_go, w_rd_en;
    logic [WIDTH-1:0]      w_ram_q;

    assign w_ar_hs = axid_ar_valid && axid_ar_ready;
    assign w_r_hs  = axid_r_valid && axid_r_ready;
    assign w_rd_go = (r_rd_state == R_FETCH) && !w_stall;
    // Refetch in R_FETCH each cycle; in R_DATA only prefetch on a non-final handshake so held data cannot change.
    assign w_rd_en = (r_rd_state == R_FETCH) || (w_r_hs && r_rd_remain != 5'd1);

    always_ff @(posedge clk) begin
        if (rst) r_rd_state <= R_IDLE;
        else     r_rd_state <= w_rd_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_next = R_FETCH;
            R_FETCH: if (!w_stall) w_rd_next = R_DATA;
            R_DATA:  if (w_r_hs && r_rd_remain == 5'd1) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        axid_ar_ready = !rst && (r_rd_state == R_IDLE) && !w_stall;
        axid_r_valid  = !rst && (r_rd_state == R_DATA);
        axid_r_last   = axid_r_valid && (r_rd_remain == 5'd1);
        axid_r_data   = (axid_r_valid && !r_rd_oor) ? w_ram_q : '0;
        axid_r_resp   = (axid_r_valid && r_rd_oor) ? RESP_DECERR : RESP_OKAY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_index  <= '0;
            r_rd_remain <= '0;
            r_rd_oor    <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_rd_index  <= axid_ar_addr[LSB +: DEPTH_BITS];
                r_rd_remain <= {1'b0, axid_ar_len} + 5'd1;
                r_rd_oor    <= (axid_ar_addr >> (LSB + DEPTH_BITS)) != 32'd0;
            end
            if (w_rd_go || (w_r_hs && r_rd_remain != 5'd1)) r_rd_index <= r_rd_index + DEPTH_BITS'(1);
            if (w_r_hs) r_rd_remain <= r_rd_remain - 5'd1;
        end
    end

    // ---------------- write channel ----------------
    w_state_t              r_wr_state, w_wr_next;
    logic [DEPTH_BITS-1:0] r_wr_index;
    logic [4:0]            r_wr_remain;
    logic                  r_wr_oor;
    logic [1:0]            r_b_resp;
    logic                  w_aw_hs, w_w_hs, w_b_hs, w_wr_en;

    assign w_aw_hs = axid_aw_valid && axid_aw_ready;
    assign w_w_hs  = axid_w_valid && axid_w_ready;
    assign w_b_hs  = axid_b_valid && axid_b_ready;
    // Beats past the announced length are accepted but dropped.
    assign w_wr_en = w_w_hs && !r_wr_oor && (r_wr_remain != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) r_wr_state <= W_IDLE;
        else     r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_aw_hs) w_wr_next = W_DATA;
            W_DATA:  if (w_w_hs && axid_w_last) w_wr_next = W_RESP;
            W_RESP:  if (w_b_hs) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        axid_aw_ready = !rst && (r_wr_state == W_IDLE) && !w_stall;
        axid_w_ready  = !rst && (r_wr_state == W_DATA) && !w_stall;
        axid_b_valid  = !rst && (r_wr_state == W_RESP);
        axid_b_resp   = axid_b_valid ? r_b_resp : RESP_OKAY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_index  <= '0;
            r_wr_remain <= '0;
            r_wr_oor    <= 1'b0;
            r_b_resp    <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_wr_index  <= axid_aw_addr[LSB +: DEPTH_BITS];
                r_wr_remain <= {1'b0, axid_aw_len} + 5'd1;
                r_wr_oor    <= (axid_aw_addr >> (LSB + DEPTH_BITS)) != 32'd0;
            end
            if (w_w_hs) begin
                r_wr_index <= r_wr_index + DEPTH_BITS'(1);
                if (r_wr_remain != 5'd0) r_wr_remain <= r_wr_remain - 5'd1;
                if (axid_w_last) begin
                    r_b_resp <= r_wr_oor ? RESP_DECERR :
                                (r_wr_remain == 5'd1) ? RESP_OKAY : RESP_SLVERR;
                end
            end
        end
    end

    dlsc_axid_ram_bytewr #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (DEPTH_BITS)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_index),
        .i_wr_data (axid_w_data),
        .i_wr_strb (axid_w_strb),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_index),
        .o_rd_data (w_ram_q)
    );

endmodule

// File: tb/tb_dlsc_axid_slave_ram.sv
// Self-checking bench for dlsc_axid_slave_ram: directed scenarios plus random
// bursts compared against a word-array memory model.
module tb_dlsc_axid_slave_ram;

    localparam int WIDTH      = 32;
    localparam int DEPTH_BITS = 10;
    localparam int WORDS      = 1 << DEPTH_BITS;

    logic        clk = 1'b0;
    logic        rst;
    logic        axid_ar_ready, axid_ar_valid;
    logic [31:0] axid_ar_addr;
    logic [3:0]  axid_ar_len;
    logic        axid_r_ready, axid_r_valid, axid_r_last;
    logic [31:0] axid_r_data;
    logic [1:0]  axid_r_resp;
    logic        axid_aw_ready, axid_aw_valid;
    logic [31:0] axid_aw_addr;
    logic [3:0]  axid_aw_len;
    logic        axid_w_ready, axid_w_valid, axid_w_last;
    logic [31:0] axid_w_data;
    logic [3:0]  axid_w_strb;
    logic        axid_b_ready, axid_b_valid;
    logic [1:0]  axid_b_resp;

    always #5 clk = ~clk;

    dlsc_axid_slave_ram #(.WIDTH(WIDTH), .DEPTH_BITS(DEPTH_BITS)) dut (
        .clk(clk), .rst(rst),
        .axid_ar_ready(axid_ar_ready), .axid_ar_valid(axid_ar_valid),
        .axid_ar_addr(axid_ar_addr), .axid_ar_len(axid_ar_len),
        .axid_r_ready(axid_r_ready), .axid_r_valid(axid_r_valid),
        .axid_r_last(axid_r_last), .axid_r_data(axid_r_data), .axid_r_resp(axid_r_resp),
        .axid_aw_ready(axid_aw_ready), .axid_aw_valid(axid_aw_valid),
        .axid_aw_addr(axid_aw_addr), .axid_aw_len(axid_aw_len),
        .axid_w_ready(axid_w_ready), .axid_w_valid(axid_w_valid),
        .axid_w_last(axid_w_last), .axid_w_data(axid_w_data), .axid_w_strb(axid_w_strb),
        .axid_b_ready(axid_b_ready), .axid_b_valid(axid_b_valid), .axid_b_resp(axid_b_resp)
    );

    logic [31:0] model [WORDS];
    logic [31:0] wbuf_data [32];
    logic [3:0]  wbuf_strb [32];
    logic [31:0] rbuf [16];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {axid_ar_ready, axid_r_valid, axid_r_last, axid_r_data, axid_r_resp,
                    axid_aw_ready, axid_w_ready, axid_b_valid, axid_b_resp}, 64'd0);
    endtask

    function automatic bit is_oor(input logic [31:0] addr);
        return addr >= 32'(WORDS * 4);
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'(addr / 4) % WORDS;
    endfunction

    // Write burst of nbeats beats using wbuf_*; updates the model and checks B.
    task automatic axi_write(input logic [31:0] addr, input int len, input int nbeats);
        int n;
        int idx;
        bit oor;
        oor = is_oor(addr);
        idx = word_of(addr);
        axid_aw_addr = addr; axid_aw_len = 4'(len); axid_aw_valid = 1'b1;
        n = 0;
        while (!axid_aw_ready && n < 200) begin @(negedge clk); n++; end
        check("aw_handshake", 64'(n < 200), 64'd1);
        @(negedge clk);
        axid_aw_valid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            axid_w_valid = 1'b1; axid_w_data = wbuf_data[b];
            axid_w_strb = wbuf_strb[b]; axid_w_last = (b == nbeats - 1);
            n = 0;
            while (!axid_w_ready && n < 200) begin @(negedge clk); n++; end
            check("w_handshake", 64'(n < 200), 64'd1);
            @(negedge clk);
            if (!oor && b <= len) begin
                for (int k = 0; k < 4; k++)
                    if (wbuf_strb[b][k]) model[(idx + b) % WORDS][k*8 +: 8] = wbuf_data[b][k*8 +: 8];
            end
        end
        axid_w_valid = 1'b0; axid_w_last = 1'b0;
        axid_b_ready = 1'b1;
        n = 0;
        while (!axid_b_valid && n < 200) begin @(negedge clk); n++; end
        check("b_handshake", 64'(n < 200), 64'd1);
        check("b_resp", axid_b_resp, oor ? 2'b11 : (nbeats == len + 1 ? 2'b00 : 2'b10));
        @(negedge clk);
        axid_b_ready = 1'b0;
        check("b_valid_after_hs", axid_b_valid, 1'b0);
    endtask

    // mode 0: r_ready always 1; mode 1: random r_ready; mode 2: hold r_ready 0 for 5 valid cycles.
    task automatic axi_read(input logic [31:0] addr, input int len, input int mode);
        int n, beat, since, stalls, idx;
        bit oor, held, seen;
        logic [31:0] h_data;
        logic        h_last;
        logic [1:0]  h_resp;
        oor = is_oor(addr);
        idx = word_of(addr);
        axid_ar_addr = addr; axid_ar_len = 4'(len); axid_ar_valid = 1'b1;
        n = 0;
        while (!axid_ar_ready && n < 200) begin @(negedge clk); n++; end
        check("ar_handshake", 64'(n < 200), 64'd1);
        @(negedge clk);
        axid_ar_valid = 1'b0;
        since = 1; beat = 0; held = 0; seen = 0; stalls = 0; n = 0;
        h_data = '0; h_last = 1'b0; h_resp = '0;
        while (beat <= len && n < 500) begin
            case (mode)
                0:       axid_r_ready = 1'b1;
                1:       axid_r_ready = 1'($urandom_range(0, 1));
                default: axid_r_ready = (stalls >= 5);
            endcase
            if (axid_r_valid) begin
                if (held) begin
                    check("r_hold_data", axid_r_data, h_data);
                    check("r_hold_last", axid_r_last, h_last);
                    check("r_hold_resp", axid_r_resp, h_resp);
                end
`ifndef DLSC_AXID_SLAVE_RAM_STALL_EN
                if (!seen) check("r_first_latency", since, 2);
`endif
                seen = 1;
                if (axid_r_ready) begin
                    check("r_data", axid_r_data, oor ? 32'd0 : model[(idx + beat) % WORDS]);
                    check("r_last", axid_r_last, 64'(beat == len));
                    check("r_resp", axid_r_resp, oor ? 2'b11 : 2'b00);
                    rbuf[beat] = axid_r_data;
                    beat++;
                    held = 0;
                end else begin
                    held = 1; h_data = axid_r_data; h_last = axid_r_last; h_resp = axid_r_resp;
                    stalls++;
                end
            end
`ifndef DLSC_AXID_SLAVE_RAM_STALL_EN
            else if (mode == 0 && beat > 0) check("r_back_to_back", axid_r_valid, 1'b1);
`endif
            @(negedge clk);
            since++; n++;
        end
        axid_r_ready = 1'b0;
        check("r_beat_count", beat, len + 1);
        check("r_valid_after_last", axid_r_valid, 1'b0);
`ifndef DLSC_AXID_SLAVE_RAM_STALL_EN
        check("ar_ready_after_last", axid_ar_ready, 1'b1);
`endif
    endtask

    initial begin
        int len, nb, sel;
        logic [31:0] addr;
        rst = 1'b1;
        axid_ar_valid = 0; axid_ar_addr = 0; axid_ar_len = 0; axid_r_ready = 0;
        axid_aw_valid = 0; axid_aw_addr = 0; axid_aw_len = 0;
        axid_w_valid = 0; axid_w_last = 0; axid_w_data = 0; axid_w_strb = 0; axid_b_ready = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        #1;
        check("post_reset_ar_ready", axid_ar_ready, 1'b1);
        check("post_reset_aw_ready", axid_aw_ready, 1'b1);
        check("idle_w_ready", axid_w_ready, 1'b0);

        // Fill the whole memory so every model word is known.
        for (int k = 0; k < WORDS / 16; k++) begin
            for (int b = 0; b < 16; b++) begin wbuf_data[b] = $urandom; wbuf_strb[b] = 4'hF; end
            axi_write(32'(k * 64), 15, 16);
        end

        // Basic burst write then read.
        wbuf_data[0] = 32'h11; wbuf_data[1] = 32'h22; wbuf_data[2] = 32'h33; wbuf_data[3] = 32'h44;
        for (int b = 0; b < 4; b++) wbuf_strb[b] = 4'hF;
        axi_write(32'h10, 3, 4);
        axi_read(32'h10, 3, 0);
        check("basic_beat0", rbuf[0], 32'h11);
        check("basic_beat1", rbuf[1], 32'h22);
        check("basic_beat2", rbuf[2], 32'h33);
        check("basic_beat3", rbuf[3], 32'h44);

        // Partial byte strobes.
        wbuf_data[0] = 32'hAABBCCDD; wbuf_strb[0] = 4'b0101;
        axi_write(32'h10, 0, 1);
        axi_read(32'h10, 0, 0);
        check("strobe_merge", rbuf[0], 32'h00BB00DD);

        // Out-of-range read and write.
        axi_read(32'h1000, 1, 1);
        check("oor_read_beat1", rbuf[1], 32'd0);
        wbuf_data[0] = 32'hDEADBEEF; wbuf_strb[0] = 4'hF;
        axi_write(32'h1000, 0, 1);
        axi_read(32'h0, 0, 0);

        // Beat-count mismatches.
        for (int b = 0; b < 4; b++) begin wbuf_data[b] = $urandom; wbuf_strb[b] = 4'hF; end
        axi_write(32'h40, 3, 2);
        for (int b = 0; b < 4; b++) begin wbuf_data[b] = $urandom; wbuf_strb[b] = 4'hF; end
        axi_write(32'h80, 1, 4);
        axi_read(32'h80, 3, 0);

        // Wrap at the top of memory, with a 5-cycle r_ready stall.
        axi_read(32'hFFC, 1, 2);
        check("wrap_beat1_word0", rbuf[1], model[0]);

        // Concurrent independent read and write.
        for (int b = 0; b < 8; b++) begin wbuf_data[b] = $urandom; wbuf_strb[b] = 4'($urandom); end
        fork
            axi_write(32'h200, 7, 8);
            axi_read(32'h400, 7, 1);
        join

        // Random bursts.
        for (int it = 0; it < 24; it++) begin
            sel = $urandom_range(0, 9);
            addr = (sel == 0) ? 32'h1000 + 32'($urandom_range(0, 65535)) : 32'($urandom_range(0, 4095));
            len = $urandom_range(0, 15);
            nb = (sel == 1) ? $urandom_range(1, 20) : len + 1;
            for (int b = 0; b < nb; b++) begin wbuf_data[b] = $urandom; wbuf_strb[b] = 4'($urandom); end
            axi_write(addr, len, nb);
            axi_read(addr, len, 1);
        end

        // Reset in the middle of a write burst.
        axid_aw_addr = 32'h300; axid_aw_len = 4'd3; axid_aw_valid = 1'b1;
        nb = 0;
        while (!axid_aw_ready && nb < 200) begin @(negedge clk); nb++; end
        @(negedge clk);
        axid_aw_valid = 1'b0;
        axid_w_valid = 1'b1; axid_w_data = 32'h0BADF00D; axid_w_strb = 4'hF; axid_w_last = 1'b0;
        nb = 0;
        while (!axid_w_ready && nb < 200) begin @(negedge clk); nb++; end
        check("rst_mid_beat1_hs", 64'(nb < 200), 64'd1);
        @(negedge clk);
        model[32'h300 / 4] = 32'h0BADF00D;
        axid_w_data = 32'h12345678;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid_outputs");
        @(negedge clk);
        check_all_zero("rst_mid_outputs_held");
        rst = 1'b0; axid_w_valid = 1'b0;
        #1;
        check("rst_mid_aw_ready", axid_aw_ready, 1'b1);
        check("rst_mid_b_valid", axid_b_valid, 1'b0);
        check("rst_mid_w_ready", axid_w_ready, 1'b0);
        axi_read(32'h300, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
